// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, legal oversampling
// ratios and the 2-of-3 majority vote.
package uart_pkg;

  localparam int unsigned PRESCALE_W = 6;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = PRESCALE_W'(32);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[1] & s[2]) | (s[0] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: edge counter, bit counter and a
// 3-point mid-bit majority sampler.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CNT_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clear_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  rx_i,
  output logic [BIT_CNT_W-1:0]  bit_cnt_o,
  output logic                  bit_done_c_o,
  output logic                  bit_val_c_o
);

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [PRESCALE_W-1:0] last_edge;
  logic [PRESCALE_W-1:0] mid;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [2:0]            samp_q, samp_d;

  // Modulo-6-bit arithmetic keeps illegal ratios (0, 1, ...) counting safely.
  assign last_edge = prescale_i - PRESCALE_W'(1);
  assign mid       = prescale_i >> 1;

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    samp_d = samp_q;
    if (clear_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (edge_q == last_edge) begin
      edge_d = '0;
      bit_d  = bit_q + BIT_CNT_W'(1);
    end else begin
      edge_d = edge_q + PRESCALE_W'(1);
    end
    if (edge_q == mid - PRESCALE_W'(1)) samp_d[0] = rx_i;
    if (edge_q == mid)                  samp_d[1] = rx_i;
    if (edge_q == mid + PRESCALE_W'(1)) samp_d[2] = rx_i;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_q <= '0;
      bit_q  <= '0;
      samp_q <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
      samp_q <= samp_d;
    end
  end

  assign bit_cnt_o    = bit_q;
  assign bit_done_c_o = (edge_q == last_edge);
  assign bit_val_c_o  = majority3(samp_q);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop FSM with LSB-first deserializer,
// parity and stop checks, and registered one-cycle result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_error,
  output logic                  stop_error
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 3);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_fail_q, par_fail_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_error_q, par_error_d;
  logic                  stop_error_q, stop_error_d;

  logic [PRESCALE_W-1:0] prescale_c;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  bit_done_c;
  logic                  bit_val_c;
  logic                  clear_c;

  // The start-detect cycle uses the live ratio; later cycles use the latched one.
  assign prescale_c = (state_q == ST_IDLE) ? Prescale : prescale_q;
  assign clear_c    = (state_d == ST_IDLE);

  uart_rx_sampler #(
    .BIT_CNT_W (BIT_CNT_W)
  ) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .clear_i      (clear_c),
    .prescale_i   (prescale_c),
    .rx_i         (RX_IN),
    .bit_cnt_o    (bit_cnt),
    .bit_done_c_o (bit_done_c),
    .bit_val_c_o  (bit_val_c)
  );

  always_comb begin
    state_d      = state_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_fail_d   = par_fail_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_error_d  = 1'b0;
    stop_error_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d    = ST_START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done_c) state_d = bit_val_c ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_done_c) begin
          shift_d = {bit_val_c, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt == BIT_CNT_W'(DATA_WIDTH)) state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_done_c) begin
          if (bit_val_c != ((^shift_q) ^ par_typ_q)) begin
            par_error_d = 1'b1;
            par_fail_d  = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done_c) begin
          state_d = ST_IDLE;
          if (!bit_val_c) begin
            stop_error_d = 1'b1;
          end else if (!par_fail_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_fail_q   <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_error_q  <= 1'b0;
      stop_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_fail_q   <= par_fail_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_error_q  <= par_error_d;
      stop_error_q <= stop_error_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_error  = par_error_q;
  assign stop_error = stop_error_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 Port CLK  input  1  receiver clock (oversampling clock); all logic on rising edge.
REQ-003 Port RST  input  1  reset; synchronous, active-high.
REQ-004 Port RX_IN  input  1  serial line; idle high; already synchronous to CLK.
REQ-005 Port Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 Port PAR_EN  input  1  1 = parity bit present after the data bits.
REQ-007 Port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 Port P_DATA  output  DATA_WIDTH  last received data word.
REQ-009 Port data_valid  output  1  one-cycle pulse; P_DATA holds a good frame.
REQ-010 Port par_error  output  1  one-cycle pulse on parity mismatch.
REQ-011 Port stop_error  output  1  one-cycle pulse on stop bit sampled low.

Function
REQ-012 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE -> START on the first CLK where RX_IN=0; that cycle is edge count 0 of the start bit.
REQ-014 Each bit SHALL span edge counts 0..Prescale-1; the edge counter wraps to 0 and the bit counter increments at Prescale-1.
REQ-015 Each bit value SHALL be the 2-of-3 majority of RX_IN at edge counts Prescale/2-1, Prescale/2, Prescale/2+1.
REQ-016 START: a majority of 1 SHALL be treated as a glitch; return to IDLE at edge count Prescale-1 with no output pulse.
REQ-017 DATA: DATA_WIDTH bits SHALL be shifted in LSB first; then -> PARITY if PAR_EN=1, else -> STOP.
REQ-018 PARITY: expected bit = XOR of data bits (even), inverted when PAR_TYP=1; on mismatch, pulse par_error in the cycle after the parity bit's last edge count.
REQ-019 STOP: at the stop bit's last edge count, majority 0 SHALL pulse stop_error in the following cycle.
REQ-020 data_valid SHALL pulse, and P_DATA SHALL update, in the cycle after the stop bit's last edge count, only if neither error occurred in that frame.
REQ-021 On par_error, the frame SHALL still complete through STOP, with no data_valid; stop_error SHALL still be reported.
REQ-022 Latency: data_valid rises exactly Prescale*(DATA_WIDTH+2+PAR_EN) cycles after the start-detect cycle.
REQ-023 Prescale, PAR_EN and PAR_TYP SHALL be latched at start detect; mid-frame changes affect only the next frame.
REQ-024 After STOP the FSM SHALL enter IDLE; RX_IN=0 in the first IDLE cycle starts a new frame (back-to-back frames supported).
REQ-025 P_DATA SHALL hold its value between frames and SHALL NOT change on error frames.
REQ-026 Illegal Prescale values give undefined framing, but the FSM SHALL never lock up and SHALL return to IDLE within one frame.

Reset
REQ-027 RST=1 at a rising CLK edge SHALL force IDLE, zero all counters, P_DATA=0, data_valid=0, par_error=0, stop_error=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no pulse; reception resumes on the first RX_IN=0 after RST deasserts.

Structure
REQ-029 The shared package uart_pkg SHALL hold the FSM state encoding and the legal Prescale constants (8, 16, 32).
REQ-030 Sub-module uart_rx_sampler SHALL contain the edge/bit counters and the 3-point majority sampler; uart_rx contains the FSM, deserializer, and parity/stop checks.

Verification
REQ-031 Prescale=8, PAR_EN=0, frame 0xA5 (0,1,0,1,0,0,1,0,1,1) -> P_DATA=0xA5, data_valid pulses 80 cycles after start detect, no errors.
REQ-032 Prescale=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 1 -> par_error pulses 160 cycles after start, no data_valid, P_DATA unchanged.
REQ-033 Prescale=32, PAR_EN=1, PAR_TYP=1, 0x81 with correct parity 1 and stop=0 -> stop_error at cycle 352, no data_valid.
REQ-034 Prescale=16, RX_IN low for 3 cycles then high -> glitch rejected, FSM in IDLE at cycle 16, no pulses; a following frame 0x5A is received correctly.
REQ-035 Prescale=8, back-to-back 0x11 and 0xEE with no idle gap -> two data_valid pulses 80 cycles apart with the correct data.
REQ-036 RST asserted at cycle 40 of a Prescale=8 frame -> all outputs 0 next cycle, no pulse for that frame; the next frame 0x7E is received correctly.
